regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and sequencer for the 16×4-bit register file's single write port. It accepts register-write requests from two requesters, the ALU writeback and the memory/load writeback, each with a valid/ready handshake. It grants at most one request per cycle and drives the register file's `regwrite`/`write_reg`/`write_data` from a registered output stage. It also exports a stall indication and a pending-destination mask for hazard logic.

## Interface
- `STARVE_LIMIT`, 3, cycles a waiting MEM request may lose to ALU before it is forced to win; legal 1..15; used only without `WB_RR_EN`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `alu_valid`  in  1  ALU write request present.
- `alu_ready`  out  1  ALU request granted this cycle.
- `alu_reg`  in  4  ALU destination register.
- `alu_data`  in  4  ALU write data.
- `mem_valid` / `mem_ready` / `mem_reg` / `mem_data`  in/out/in/in  1/1/4/4  same fields for the MEM requester.
- `regwrite`  out  1  register-file write enable (registered).
- `write_reg`  out  4  register-file write address (registered).
- `write_data`  out  4  register-file write data (registered).
- `stall`  out  1  some requester is valid but not granted this cycle.
- `pending`  out  16  bit i set if register i has an uncommitted write.

## Operation
- **Transfer:** a transfer happens when `valid & ready`. `ready` is combinational from both `valid` inputs and the arbitration state.
  - At most one `ready` is high per cycle.
  - `ready` is 0 whenever its own `valid` is 0.
- **Requester rules:** a requester holds `valid`, `reg` and `data` stable until its transfer. Withdrawing `valid` before the transfer is a protocol violation, and the resulting behaviour is undefined.
- **Output stage on a transfer:**
  - `regwrite <= (reg != 0)`.
  - `write_reg <= reg`.
  - `write_data <= data`.
  - Writes to r0 are consumed (`ready` = 1) but never asserted to the register file.
- **Output stage with no transfer:** `regwrite <= 0`; `write_reg` and `write_data` hold.
- **Same-destination collision:** when both requesters target the same register, one is granted per the policy below and the other follows on a later cycle. The register's final value is the later grant's data.
- **Stall:** `stall = (alu_valid & !alu_ready) | (mem_valid & !mem_ready)`.
- **Pending mask:** `pending[i]` is set when either of these holds:
  - `regwrite` = 1 and `write_reg` == i, or
  - a valid requester with destination i, where i != 0, has not yet transferred.
- **Policy without the macro:** fixed priority, ALU first, with a 4-bit starvation counter `mem_wait`.
  - `mem_wait` increments (saturating at 15) each cycle that `mem_valid & !mem_ready`.
  - `mem_wait` clears on a MEM transfer.
  - When `mem_wait >= STARVE_LIMIT` and both are valid, MEM wins.
- **Lone requester:** if only one requester is valid, it is always granted, under either policy.

## Timing
- Handshake at edge N: `regwrite`/`write_reg`/`write_data` are valid after edge N.
- The register file commits at edge N+1, and the new value is readable on its read ports after edge N+1.
- Back-to-back: one transfer per cycle sustained; `regwrite` may stay high on consecutive cycles.
- Output values during and after reset:
  - `regwrite` = 0, `write_reg` = 0, `write_data` = 0.
  - `mem_wait` = 0; round-robin pointer = MEM.
  - `ready` and `stall` follow their combinational equations; the first tie after reset goes to ALU.
- Reset asserted mid-operation:
  - The output stage clears immediately, without waiting for a clock edge.
  - A write registered but not yet committed is lost.
  - Requests still held valid are re-arbitrated after reset deasserts.
- `ready`, `stall` and `pending` are combinational, with no registered delay. Requesters must not make `valid` depend on `ready`.

## Configuration
- `WB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester.
  - On a tie, the other requester wins.
  - `STARVE_LIMIT` and `mem_wait` are not implemented.
- `WB_RR_EN` undefined: fixed ALU priority with the `STARVE_LIMIT` starvation guard described above.

## Test plan
- **Reset values:** reset high, then released → `regwrite`/`write_reg`/`write_data` = 0 and `pending` = 0.
- **Single ALU write:** ALU valid, reg 5, data 0xA, one cycle → `alu_ready` = 1 that cycle. The next cycle shows `regwrite` = 1, `write_reg` = 5, `write_data` = 0xA. Register 5 reads 0xA after the following edge.
- **Write to r0:** MEM valid, reg 0, data 0xF → `mem_ready` = 1, `regwrite` stays 0, `pending[0]` = 0.
- **Collision (fixed priority):** both valid, reg 3, ALU = 0x1, MEM = 0x2 → ALU granted first, MEM next. `pending[3]` is high throughout, and register 3 ends at 0x2.
- **Starvation (fixed priority, `STARVE_LIMIT` = 3):** ALU continuously valid, MEM valid from cycle 0 → MEM is granted at cycle 3 while ALU is still valid, and `stall` = 1 in cycles 0–2.
- **Reset mid-operation:** reset asserted between a transfer edge and its commit edge → `regwrite` drops to 0 immediately and the write is not committed. After release, a held request transfers on the first edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request/grant and register-file write bundle
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_reg;
  logic [3:0]  alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_reg;
  logic [3:0]  mem_data;
  logic        regwrite;
  logic [3:0]  write_reg;
  logic [3:0]  write_data;
  logic        stall;
  logic [15:0] pending;
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, regwrite, write_reg, write_data, stall, pending
  );
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, regwrite, write_reg, write_data, stall, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/MEM writeback arbiter; define WB_RR_EN for round-robin, else ALU priority with starvation guard
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic                  clock,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  wb
);
  logic       mem_win;
  logic       regwrite_q, regwrite_d;
  logic [3:0] write_reg_q, write_reg_d;
  logic [3:0] write_data_q, write_data_d;
  logic [15:0] pending_d;
`ifdef WB_RR_EN
  logic ptr_q, ptr_d;
  assign mem_win = !ptr_q;
  // remember last granted requester (1 = MEM) so ties alternate
  always_comb ptr_d = wb.alu_ready ? 1'b0 : wb.mem_ready ? 1'b1 : ptr_q;
  // round-robin pointer register
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr_q <= 1'b1;
    else       ptr_q <= ptr_d;
`else
  logic [3:0] mem_wait_q, mem_wait_d;
  assign mem_win = mem_wait_q >= 4'(STARVE_LIMIT);
  // count cycles MEM loses, saturating; a MEM grant clears it
  always_comb
    mem_wait_d = wb.mem_ready ? 4'd0 :
                 (wb.mem_valid && mem_wait_q != 4'hf) ? mem_wait_q + 4'd1 : mem_wait_q;
  // starvation counter register
  always_ff @(posedge clock or posedge reset)
    if (reset) mem_wait_q <= 4'd0;
    else       mem_wait_q <= mem_wait_d;
`endif
  assign wb.alu_ready  = wb.alu_valid & (!wb.mem_valid | !mem_win);
  assign wb.mem_ready  = wb.mem_valid & (!wb.alu_valid | mem_win);
  assign wb.stall      = (wb.alu_valid & !wb.alu_ready) | (wb.mem_valid & !wb.mem_ready);
  assign wb.regwrite   = regwrite_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;
  assign wb.pending    = pending_d;
  // output stage next state: load the granted request, r0 writes are swallowed
  always_comb begin
    regwrite_d   = wb.alu_ready ? (wb.alu_reg != 4'd0) : wb.mem_ready ? (wb.mem_reg != 4'd0) : 1'b0;
    write_reg_d  = wb.alu_ready ? wb.alu_reg  : wb.mem_ready ? wb.mem_reg  : write_reg_q;
    write_data_d = wb.alu_ready ? wb.alu_data : wb.mem_ready ? wb.mem_data : write_data_q;
  end
  // registered write port towards the register file
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= 4'd0;
      write_data_q <= 4'd0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  // destinations with a write in flight: committing now or still requested
  always_comb begin
    pending_d = '0;
    for (int i = 1; i < 16; i++)
      pending_d[i] = (regwrite_q && write_reg_q == 4'(i)) ||
                     (wb.alu_valid && wb.alu_reg == 4'(i)) ||
                     (wb.mem_valid && wb.mem_reg == 4'(i));
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of the writeback arbiter with a behavioural register file
module tb_regfile_wb_arbiter;
  logic clk, rst;
  int checks, errors;
  logic [3:0] rf [16];
  regfile_wb_arbiter_if wb ();
  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (.clock(clk), .reset(rst), .wb(wb));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // external register file: commits one edge after the registered write port
  always @(posedge clk)
    if (wb.regwrite) rf[wb.write_reg] <= wb.write_data;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) rf[i] = 4'd0;
    rst = 1'b1;
    wb.alu_valid = 1'b0; wb.alu_reg = 4'd0; wb.alu_data = 4'd0;
    wb.mem_valid = 1'b0; wb.mem_reg = 4'd0; wb.mem_data = 4'd0;
    tick(); tick();
    check("rst_regwrite", 16'(wb.regwrite), 16'd0);
    check("rst_write_reg", 16'(wb.write_reg), 16'd0);
    check("rst_write_data", 16'(wb.write_data), 16'd0);
    check("rst_pending", wb.pending, 16'h0000);
    rst = 1'b0;
    tick();
    check("rel_regwrite", 16'(wb.regwrite), 16'd0);
    check("rel_pending", wb.pending, 16'h0000);
    wb.alu_valid = 1'b1; wb.alu_reg = 4'd5; wb.alu_data = 4'ha;
    #1;
    check("alu_ready", 16'(wb.alu_ready), 16'd1);
    check("alu_stall", 16'(wb.stall), 16'd0);
    check("alu_pending_req", wb.pending, 16'h0020);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    check("alu_regwrite", 16'(wb.regwrite), 16'd1);
    check("alu_write_reg", 16'(wb.write_reg), 16'd5);
    check("alu_write_data", 16'(wb.write_data), 16'ha);
    check("alu_pending_wb", wb.pending, 16'h0020);
    tick();
    check("alu_rf5", 16'(rf[5]), 16'ha);
    check("alu_idle_regwrite", 16'(wb.regwrite), 16'd0);
    wb.mem_valid = 1'b1; wb.mem_reg = 4'd0; wb.mem_data = 4'hf;
    #1;
    check("r0_mem_ready", 16'(wb.mem_ready), 16'd1);
    check("r0_pending", wb.pending, 16'h0000);
    tick();
    wb.mem_valid = 1'b0;
    #1;
    check("r0_regwrite", 16'(wb.regwrite), 16'd0);
    check("r0_write_data", 16'(wb.write_data), 16'hf);
    check("r0_pending_after", wb.pending, 16'h0000);
    wb.alu_valid = 1'b1; wb.alu_reg = 4'd3; wb.alu_data = 4'h1;
    wb.mem_valid = 1'b1; wb.mem_reg = 4'd3; wb.mem_data = 4'h2;
    #1;
    check("col_alu_ready", 16'(wb.alu_ready), 16'd1);
    check("col_mem_ready", 16'(wb.mem_ready), 16'd0);
    check("col_stall", 16'(wb.stall), 16'd1);
    check("col_pending_c0", wb.pending, 16'h0008);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    check("col_mem_ready2", 16'(wb.mem_ready), 16'd1);
    check("col_wdata1", 16'(wb.write_data), 16'h1);
    check("col_pending_c1", wb.pending, 16'h0008);
    tick();
    wb.mem_valid = 1'b0;
    #1;
    check("col_regwrite2", 16'(wb.regwrite), 16'd1);
    check("col_wdata2", 16'(wb.write_data), 16'h2);
    check("col_pending_c2", wb.pending, 16'h0008);
    tick();
    check("col_rf3", 16'(rf[3]), 16'h2);
`ifndef WB_RR_EN
    wb.alu_valid = 1'b1; wb.alu_reg = 4'd1; wb.alu_data = 4'h4;
    wb.mem_valid = 1'b1; wb.mem_reg = 4'd2; wb.mem_data = 4'h7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("starve_mem_ready", 16'(wb.mem_ready), 16'd0);
      check("starve_stall", 16'(wb.stall), 16'd1);
      tick();
    end
    #1;
    check("starve_mem_win", 16'(wb.mem_ready), 16'd1);
    check("starve_alu_lose", 16'(wb.alu_ready), 16'd0);
    tick();
    wb.mem_valid = 1'b0;
    #1;
    check("starve_write_reg", 16'(wb.write_reg), 16'd2);
    check("starve_write_data", 16'(wb.write_data), 16'h7);
    check("starve_alu_alone", 16'(wb.alu_ready), 16'd1);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    check("starve_alu_write_reg", 16'(wb.write_reg), 16'd1);
    tick();
`endif
    wb.alu_valid = 1'b1; wb.alu_reg = 4'd6; wb.alu_data = 4'h9;
    tick();
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b1; wb.mem_reg = 4'd7; wb.mem_data = 4'h5;
    #1;
    check("mid_regwrite_pre", 16'(wb.regwrite), 16'd1);
    rst = 1'b1;
    #1;
    check("mid_regwrite_async", 16'(wb.regwrite), 16'd0);
    check("mid_write_reg_async", 16'(wb.write_reg), 16'd0);
    tick();
    check("mid_rf6_lost", 16'(rf[6]), 16'd0);
    check("mid_rf7_none", 16'(rf[7]), 16'd0);
    rst = 1'b0;
    #1;
    check("mid_mem_ready", 16'(wb.mem_ready), 16'd1);
    tick();
    wb.mem_valid = 1'b0;
    check("mid_regwrite_after", 16'(wb.regwrite), 16'd1);
    check("mid_write_reg_after", 16'(wb.write_reg), 16'd7);
    check("mid_write_data_after", 16'(wb.write_data), 16'h5);
    tick();
    check("mid_rf7", 16'(rf[7]), 16'h5);
    check("mid_rf6_still_lost", 16'(rf[6]), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
